// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared constants, types and code mapping for the text line renderer
package text_pkg;
    localparam int GLYPH_W = 16;
    localparam int GLYPH_H = 16;
    localparam logic [4:0] CHAR_SPACE = 5'd26;
    localparam int NUM_GLYPHS = 27;

    typedef logic [4:0] char_code_t;
    typedef logic [15:0] rgb565_t;

    typedef enum logic {
        IDLE,
        CLEAR
    } buf_state_t;

    // Codes beyond the last glyph render as space so the ROM index stays in range.
    function automatic char_code_t map_code(input char_code_t code);
        return (code > CHAR_SPACE) ? CHAR_SPACE : code;
    endfunction
endpackage

// File: rtl/text_char_buf.sv
// rtl/text_char_buf.sv - character line buffer with write port and sequential clear
module text_char_buf
    import text_pkg::*;
#(
    parameter int CHARS = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  char_code_t wr_char,
    output logic       wr_ready,
    input  logic       clr,
    input  logic [4:0] rd_col,
    output char_code_t rd_char
);
    char_code_t mem [CHARS];
    buf_state_t state;
    logic [4:0] clr_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHARS; i++) begin
                mem[i] <= CHAR_SPACE;
            end
            state    <= IDLE;
            clr_idx  <= 5'd0;
            wr_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en && wr_ready && (32'(wr_addr) < CHARS)) begin
                        mem[wr_addr] <= map_code(wr_char);
                    end
                    // A same-cycle write still lands; the clear sweep overwrites it.
                    if (clr) begin
                        state    <= CLEAR;
                        clr_idx  <= 5'd0;
                        wr_ready <= 1'b0;
                    end else begin
                        wr_ready <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[clr_idx] <= CHAR_SPACE;
                    if (32'(clr_idx) == CHARS - 1) begin
                        state    <= IDLE;
                        wr_ready <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_char = (32'(rd_col) < CHARS) ? mem[rd_col] : CHAR_SPACE;
endmodule

// File: rtl/text_line_render.sv
// rtl/text_line_render.sv - maps pixels to character cells, drives glyph ROM, overlays text
module text_line_render
    import text_pkg::*;
#(
    parameter int      TXT_X0       = 64,
    parameter int      TXT_Y0       = 32,
    parameter int      CHARS        = 32,
    parameter int      SCALE_LOG2   = 1,
    parameter rgb565_t FG_RGB       = 16'hFFFF,
    parameter int      BLINK_FRAMES = 30
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        pix_valid,
    input  logic        frame_start,
    input  rgb565_t     bg_rgb,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  char_code_t  wr_char,
    output logic        wr_ready,
    input  logic        clr,
    input  logic        blink_en,
    output char_code_t  letter_i,
    output logic [3:0]  letter_x,
    output logic [3:0]  letter_y,
    input  logic        letter_o,
    output rgb565_t     rgb_out,
    output logic        rgb_valid
);
    localparam int CELL = GLYPH_W << SCALE_LOG2;
    localparam logic [10:0] X0 = 11'(TXT_X0);
    localparam logic [10:0] Y0 = 11'(TXT_Y0);
    // 12-bit width so a full 32-cell line at 4x (2048 px) does not wrap to zero.
    localparam logic [11:0] WIN_W = 12'(CHARS * CELL);
    localparam logic [10:0] WIN_H = 11'(GLYPH_H << SCALE_LOG2);
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [10:0] dx, dy;
    logic        in_win;
    logic [4:0]  col;
    logic [3:0]  gx, gy;
    char_code_t  rd_char;

    assign dx     = {1'b0, pix_x} - X0;
    assign dy     = {1'b0, pix_y} - Y0;
    assign in_win = pix_valid && ({1'b0, pix_x} >= X0) && ({1'b0, dx} < WIN_W)
                    && ({1'b0, pix_y} >= Y0) && (dy < WIN_H);
    assign col    = 5'(dx >> (4 + SCALE_LOG2));
    assign gx     = 4'(dx >> SCALE_LOG2);
    assign gy     = 4'(dy >> SCALE_LOG2);

    text_char_buf #(
        .CHARS(CHARS)
    ) u_char_buf (
        .clk     (vga_clk),
        .rst     (sys_rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_char (wr_char),
        .wr_ready(wr_ready),
        .clr     (clr),
        .rd_col  (col),
        .rd_char (rd_char)
    );

    logic          s1_win, s1_valid, blink_hidden, visible;
    rgb565_t       s1_bg;
    logic [CW-1:0] blink_cnt;

    assign visible = !blink_en || !blink_hidden;

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            letter_i  <= '0;
            letter_x  <= '0;
            letter_y  <= '0;
            s1_win    <= 1'b0;
            s1_valid  <= 1'b0;
            s1_bg     <= '0;
            rgb_out   <= '0;
            rgb_valid <= 1'b0;
        end else begin
            letter_i  <= in_win ? rd_char : CHAR_SPACE;
            letter_x  <= in_win ? gx : 4'd0;
            letter_y  <= in_win ? gy : 4'd0;
            s1_win    <= in_win;
            s1_valid  <= pix_valid;
            s1_bg     <= bg_rgb;
            rgb_out   <= (s1_win && letter_o && visible) ? FG_RGB : s1_bg;
            rgb_valid <= s1_valid;
        end
    end

    // The phase only moves on frame_start, so a frame is never half-blinked.
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (frame_start) begin
            if (32'(blink_cnt) == BLINK_FRAMES - 1) begin
                blink_cnt    <= '0;
                blink_hidden <= !blink_hidden;
            end else begin
                blink_cnt <= blink_cnt + CW'(1);
            end
        end
    end
endmodule
